jt6295_deacc: RTL and testbench



---
 rtl/jt6295_pkg.sv | 10 +
 rtl/jt6295_deacc_lerp.sv | 22 ++
 rtl/jt6295_deacc.sv | 60 ++++++
 tb/tb_jt6295_deacc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_pkg.sv
// Shared widths and constants for the jt6295 sub-sample de-accumulator.
// The interpolator needs CALC_W bits so 4*prev + 4*delta never wraps.
package jt6295_pkg;
    localparam int RATE      = 4;
    localparam int PHASE_W   = 3;
    localparam int PHASE_MAX = 4;
    localparam int ACC_W     = 14;
    localparam int SND_W     = 12;
    localparam int CALC_W    = 18;
endpackage

// File: rtl/jt6295_deacc_lerp.sv
// Combinational linear interpolator: (4*prev + phase*delta) >>> 4.
// The sum is kept exact at full width so the arithmetic shift floors correctly.
module jt6295_deacc_lerp
    import jt6295_pkg::*;
(
    input  logic signed [ACC_W-1:0]  prev,
    input  logic signed [ACC_W:0]    delta,
    input  logic        [PHASE_W-1:0] phase,
    output logic signed [SND_W-1:0]  result
);
    logic signed [CALC_W-1:0] prev_x4;
    logic signed [CALC_W-1:0] step;
    logic signed [CALC_W-1:0] sum;

    always_comb begin
        prev_x4 = CALC_W'(prev) <<< 2;
        step    = CALC_W'($signed({1'b0, phase})) * CALC_W'(delta);
        sum     = prev_x4 + step;
        // result lies between prev/4 and cur/4, so dropping the top bits is exact
        result  = SND_W'(sum >>> 4);
    end
endmodule

// File: rtl/jt6295_deacc.sv
// Regenerates a 12-bit cen4-rate stream from 14-bit accumulated cen-rate samples,
// either held (INTERPOL=0) or linearly interpolated across the previous interval.
module jt6295_deacc
    import jt6295_pkg::*;
#(
    parameter int INTERPOL = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic                    cen4,
    input  logic signed [ACC_W-1:0] sound_in,
    output logic signed [SND_W-1:0] sound_out,
    output logic                    sample
);
    logic signed [ACC_W-1:0]  prev;
    logic signed [ACC_W-1:0]  cur;
    logic signed [ACC_W:0]    delta;
    logic        [PHASE_W-1:0] phase;
    logic signed [SND_W-1:0]  next_out;

    generate
        if (INTERPOL != 0) begin : g_lerp
            jt6295_deacc_lerp u_lerp (
                .prev   (prev),
                .delta  (delta),
                .phase  (phase),
                .result (next_out)
            );
        end else begin : g_hold
            assign next_out = SND_W'(cur >>> 2);
        end
    endgenerate

    // Output uses pre-edge state: one cen4 tick of pipeline behind the latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            cur       <= '0;
            delta     <= '0;
            phase     <= '0;
            sound_out <= '0;
            sample    <= 1'b0;
        end else begin
            sample <= cen4;
            if (cen4) begin
                sound_out <= next_out;
                if (cen) begin
                    prev  <= cur;
                    cur   <= sound_in;
                    delta <= (ACC_W+1)'(sound_in) - (ACC_W+1)'(cur);
                    phase <= '0;
                end else if (phase != PHASE_W'(PHASE_MAX)) begin
                    // saturating at PHASE_MAX makes a starved interval hold cur/4
                    phase <= phase + PHASE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_jt6295_deacc.sv
// Self-checking bench for jt6295_deacc: interpolating and hold instances side by side,
// compared against an arithmetic reference model of the output stream.
module tb_jt6295_deacc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b0;
    logic cen4 = 1'b0;
    logic signed [13:0] sound_in = '0;
    logic signed [11:0] out_i, out_h;
    logic smp_i, smp_h;

    int vectors = 0;
    int miscompares = 0;

    // reference model: last two latched samples and cen4 ticks since the latch
    int m_prev = 0, m_cur = 0, m_k = 0;
    int exp_i = 0, exp_h = 0;

    jt6295_deacc #(.INTERPOL(1)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cen4(cen4),
        .sound_in(sound_in), .sound_out(out_i), .sample(smp_i)
    );

    jt6295_deacc #(.INTERPOL(0)) dut_hold (
        .clk(clk), .rst(rst), .cen(cen), .cen4(cen4),
        .sound_in(sound_in), .sound_out(out_h), .sample(smp_h)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // One cen4 tick; exp_i/exp_h get the value the DUTs should present after it.
    task automatic tick(input bit c, input int din);
        @(negedge clk);
        cen4 = 1'b1;
        cen = c;
        sound_in = 14'(din);
        @(posedge clk);
        exp_i = fdiv(4 * m_prev + m_k * (m_cur - m_prev), 16);
        exp_h = fdiv(m_cur, 4);
        if (c) begin
            m_prev = m_cur;
            m_cur = din;
            m_k = 0;
        end else if (m_k < 4) begin
            m_k++;
        end
        #1;
    endtask

    // Cycles without cen4; cen and sound_in carry junk that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cen4 = 1'b0;
            cen = 1'($urandom_range(0, 1));
            sound_in = 14'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            cen4 = (i % 2 == 0);
            cen = 1'($urandom_range(0, 1));
            sound_in = 14'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b0;
        cen4 = 1'b0;
        cen = 1'b0;
        m_prev = 0;
        m_cur = 0;
        m_k = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1;
            cen4 = (i % 2 == 0);
            cen = 1'b1;
            sound_in = 14'sd1234;
            @(posedge clk);
            #1;
            vectors++;
            if ({out_i, out_h, smp_i, smp_h} !== 26'd0) begin
                miscompares++;
                $display("FAIL reset cycle %0d: out_i=%0d out_h=%0d smp_i=%b smp_h=%b, want all 0",
                         i, out_i, out_h, smp_i, smp_h);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        cen4 = 1'b0;
        cen = 1'b0;
        m_prev = 0;
        m_cur = 0;
        m_k = 0;
        tick(1'b1, 777);
        vectors++;
        if (out_i !== 12'sd0 || out_h !== 12'sd0) begin
            miscompares++;
            $display("FAIL reset_first_out: out_i=%0d out_h=%0d, want 0", out_i, out_h);
        end
    endtask

    task automatic test_hold();
        apply_reset(2);
        tick(1'b1, 400);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 0);
            vectors++;
            if (out_h !== 12'sd100 || out_h !== 12'(exp_h)) begin
                miscompares++;
                $display("FAIL hold tick %0d: out_h=%0d, want 100 (model %0d)", k, out_h, exp_h);
            end
            vectors++;
            if (out_i !== 12'(exp_i)) begin
                miscompares++;
                $display("FAIL hold_interp tick %0d: out_i=%0d, want %0d", k, out_i, exp_i);
            end
            vectors++;
            if (smp_i !== 1'b1 || smp_h !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_sample_hi tick %0d: smp_i=%b smp_h=%b, want 1", k, smp_i, smp_h);
            end
            idle(1);
            vectors++;
            if (smp_i !== 1'b0 || smp_h !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_sample_lo tick %0d: smp_i=%b smp_h=%b, want 0", k, smp_i, smp_h);
            end
        end
    endtask

    task automatic test_ramp();
        bit cs[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        int want[8] = '{0, 25, 50, 75, 100, 100, 100, 100};
        apply_reset(2);
        tick(1'b1, 0);
        for (int k = 0; k < 3; k++) tick(1'b0, 0);
        tick(1'b1, 400);
        for (int k = 0; k < 8; k++) begin
            idle($urandom_range(0, 3));
            tick(cs[k], 400);
            vectors++;
            if (out_i !== 12'(want[k]) || out_i !== 12'(exp_i)) begin
                miscompares++;
                $display("FAIL ramp tick %0d: out_i=%0d, want %0d (model %0d)", k, out_i, want[k], exp_i);
            end
            vectors++;
            if (out_h !== 12'(exp_h)) begin
                miscompares++;
                $display("FAIL ramp_hold tick %0d: out_h=%0d, want %0d", k, out_h, exp_h);
            end
        end
    endtask

    task automatic test_floor();
        int want[4] = '{0, -1, -1, -1};
        apply_reset(1);
        tick(1'b1, 0);
        tick(1'b1, -5);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 0);
            vectors++;
            if (out_i !== 12'(want[k]) || out_i !== 12'(exp_i)) begin
                miscompares++;
                $display("FAIL floor phase %0d: out_i=%0d, want %0d (model %0d)", k, out_i, want[k], exp_i);
            end
            vectors++;
            if (out_h !== -12'sd2) begin
                miscompares++;
                $display("FAIL floor_hold phase %0d: out_h=%0d, want -2", k, out_h);
            end
        end
    endtask

    task automatic test_extremes();
        for (int rev = 0; rev < 2; rev++) begin
            int a, b, w0, w3;
            a  = (rev != 0) ? -8192 : 8191;
            b  = (rev != 0) ? 8191 : -8192;
            w0 = (rev != 0) ? -2048 : 2047;
            w3 = (rev != 0) ? 1023 : -1025;
            apply_reset(1);
            tick(1'b1, a);
            tick(1'b1, b);
            for (int k = 0; k < 4; k++) begin
                tick(1'b0, 0);
                vectors++;
                if (out_i !== 12'(exp_i)) begin
                    miscompares++;
                    $display("FAIL extreme rev=%0d phase %0d: out_i=%0d, want %0d", rev, k, out_i, exp_i);
                end
                if (k == 0 || k == 3) begin
                    vectors++;
                    if (out_i !== 12'((k == 0) ? w0 : w3)) begin
                        miscompares++;
                        $display("FAIL extreme_const rev=%0d phase %0d: out_i=%0d, want %0d",
                                 rev, k, out_i, (k == 0) ? w0 : w3);
                    end
                end
            end
        end
    endtask

    task automatic test_starve();
        int want[8] = '{0, 25, 50, 75, 100, 100, 100, 100};
        int tail[3] = '{0, 0, 50};
        apply_reset(1);
        tick(1'b1, 0);
        tick(1'b1, 400);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 0);
            vectors++;
            if (out_i !== 12'(want[k]) || out_i !== 12'(exp_i)) begin
                miscompares++;
                $display("FAIL starve tick %0d: out_i=%0d, want %0d (model %0d)", k, out_i, want[k], exp_i);
            end
        end
        tick(1'b1, -1000);
        tick(1'b0, 0);
        tick(1'b0, 0);
        apply_reset(1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 0);
            vectors++;
            if (out_i !== 12'sd0 || out_h !== 12'sd0) begin
                miscompares++;
                $display("FAIL midreset tick %0d: out_i=%0d out_h=%0d, want 0", k, out_i, out_h);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick(k == 0, 800);
            vectors++;
            if (out_i !== 12'(tail[k]) || out_i !== 12'(exp_i)) begin
                miscompares++;
                $display("FAIL postreset tick %0d: out_i=%0d, want %0d (model %0d)", k, out_i, tail[k], exp_i);
            end
        end
    endtask

    task automatic test_random();
        apply_reset(2);
        for (int n = 0; n < 400; n++) begin
            int gap;
            tick($urandom_range(0, 2) == 0, int'($urandom_range(0, 16383)) - 8192);
            vectors++;
            if (out_i !== 12'(exp_i) || out_h !== 12'(exp_h)) begin
                miscompares++;
                $display("FAIL random %0d: out_i=%0d out_h=%0d, want %0d / %0d", n, out_i, out_h, exp_i, exp_h);
            end
            vectors++;
            if (smp_i !== 1'b1 || smp_h !== 1'b1) begin
                miscompares++;
                $display("FAIL random_sample %0d: smp_i=%b smp_h=%b, want 1", n, smp_i, smp_h);
            end
            gap = $urandom_range(0, 3);
            idle(gap);
            if (gap > 0) begin
                vectors++;
                if (smp_i !== 1'b0 || smp_h !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random_idle %0d: smp_i=%b smp_h=%b, want 0", n, smp_i, smp_h);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_ramp();
        test_floor();
        test_extremes();
        test_starve();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
